// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - instruction sequencer: accepts one instruction and runs it as EXEC, MEM or ALU.
//
// Purpose: latches an instruction, then sequences either a single-cycle
// strobe (EXEC), a memory handshake with optional timeout (MEM), or an
// ALU strobe of fixed width (ALU). Each instruction retires with done or err.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   instr_valid, instr     instruction offer {opcode, operand}
//   instr_ready            high while IDLE
//   mem_req, mem_we        memory request / write qualifier
//   mem_ack                memory completion, only looked at in MEM
//   addr_offset, nibble_out, reg_sel, alu_shamt   latched operand
//   reg16_dst, reg16_src   upper / lower halves of the latched operand
//   alu_op                 latched opcode without its MSB
//   alu_clk                ALU strobe, ALU_PULSE cycles wide
//   mva, mvb, nibble_read  single-cycle EXEC strobes
//   nibble_hl              level, latched opcode is LNH
//   busy                   state is not IDLE
//   done, err              retire / timeout pulses
module ctrl_seq #(
    parameter int OPC_W     = 4,
    parameter int OPR_W     = 4,
    parameter int ALU_PULSE = 1,
    parameter int MEM_TMO   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [OPC_W+OPR_W-1:0] instr,
    output logic                   instr_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    input  logic                   mem_ack,
    output logic [OPR_W-1:0]       addr_offset,
    output logic [OPR_W-1:0]       nibble_out,
    output logic [OPR_W-1:0]       reg_sel,
    output logic [OPR_W/2-1:0]     reg16_dst,
    output logic [OPR_W/2-1:0]     reg16_src,
    output logic [OPC_W-2:0]       alu_op,
    output logic [OPR_W-1:0]       alu_shamt,
    output logic                   alu_clk,
    output logic                   mva,
    output logic                   mvb,
    output logic                   nibble_read,
    output logic                   nibble_hl,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int IR_W      = OPC_W + OPR_W;
    // Opcode MSB clear marks an ALU-class opcode; the remaining opcodes
    // live in the upper half of the opcode space.
    localparam int ARITH_BIT = OPC_W - 1;
    localparam logic [OPC_W-1:0] OP_MVA = {1'b1, (OPC_W-1)'(0)};
    localparam logic [OPC_W-1:0] OP_MVB = {1'b1, (OPC_W-1)'(1)};
    localparam logic [OPC_W-1:0] OP_LDB = {1'b1, (OPC_W-1)'(2)};
    localparam logic [OPC_W-1:0] OP_STB = {1'b1, (OPC_W-1)'(3)};
    localparam logic [OPC_W-1:0] OP_LNL = {1'b1, (OPC_W-1)'(4)};
    localparam logic [OPC_W-1:0] OP_LNH = {1'b1, (OPC_W-1)'(5)};

    // One counter serves both the ALU pulse (<=15) and the memory timeout.
    localparam int CNT_W = (MEM_TMO > 15) ? $clog2(MEM_TMO + 1) : 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_ALU
    } state_t;

    state_t           state;
    logic [IR_W-1:0]  ir;
    logic [CNT_W-1:0] cnt;

    logic [OPC_W-1:0] in_opc;
    logic [OPC_W-1:0] ir_opc;
    logic [OPR_W-1:0] ir_opr;

    assign in_opc = instr[IR_W-1:OPR_W];
    assign ir_opc = ir[IR_W-1:OPR_W];
    assign ir_opr = ir[OPR_W-1:0];

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

    assign addr_offset = ir_opr;
    assign nibble_out  = ir_opr;
    assign reg_sel     = ir_opr;
    assign alu_shamt   = ir_opr;
    assign reg16_dst   = ir_opr[OPR_W-1:OPR_W/2];
    assign reg16_src   = ir_opr[OPR_W/2-1:0];
    assign alu_op      = ir_opc[OPC_W-2:0];
    assign nibble_hl   = (ir_opc == OP_LNH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ir          <= '0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            alu_clk     <= 1'b0;
            mva         <= 1'b0;
            mvb         <= 1'b0;
            nibble_read <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Pulses default low; each is set for exactly one cycle below.
            done        <= 1'b0;
            err         <= 1'b0;
            mva         <= 1'b0;
            mvb         <= 1'b0;
            nibble_read <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir  <= instr;
                        cnt <= '0;
                        if (in_opc == OP_LDB || in_opc == OP_STB) begin
                            state   <= S_MEM;
                            mem_req <= 1'b1;
                            mem_we  <= (in_opc == OP_STB);
                        end else if (!in_opc[ARITH_BIT]) begin
                            state   <= S_ALU;
                            alu_clk <= 1'b1;
                            // A one-cycle pulse retires on its only high cycle.
                            done    <= (ALU_PULSE == 1);
                        end else begin
                            state       <= S_EXEC;
                            mva         <= (in_opc == OP_MVA);
                            mvb         <= (in_opc == OP_MVB);
                            nibble_read <= (in_opc == OP_LNL) || (in_opc == OP_LNH);
                            done        <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                end
                S_MEM: begin
                    // An ack on the timeout cycle still counts as a completion.
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end else if (MEM_TMO != 0 && cnt == CNT_W'(MEM_TMO - 1)) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ALU: begin
                    if (cnt == CNT_W'(ALU_PULSE - 1)) begin
                        state   <= S_IDLE;
                        alu_clk <= 1'b0;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        // Raise done so it lands on the final high cycle.
                        done <= (cnt == CNT_W'(ALU_PULSE - 2));
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - self-checking bench for ctrl_seq (ALU_PULSE=3, MEM_TMO=4).
module tb_ctrl_seq;

    localparam logic [3:0] OP_MVA = 4'h8;
    localparam logic [3:0] OP_MVB = 4'h9;
    localparam logic [3:0] OP_LDB = 4'hA;
    localparam logic [3:0] OP_STB = 4'hB;
    localparam logic [3:0] OP_LNL = 4'hC;
    localparam logic [3:0] OP_LNH = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic [3:0] addr_offset;
    logic [3:0] nibble_out;
    logic [3:0] reg_sel;
    logic [1:0] reg16_dst;
    logic [1:0] reg16_src;
    logic [2:0] alu_op;
    logic [3:0] alu_shamt;
    logic       alu_clk;
    logic       mva;
    logic       mvb;
    logic       nibble_read;
    logic       nibble_hl;
    logic       busy;
    logic       done;
    logic       err;

    ctrl_seq #(
        .OPC_W(4),
        .OPR_W(4),
        .ALU_PULSE(3),
        .MEM_TMO(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ready(instr_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_ack(mem_ack),
        .addr_offset(addr_offset),
        .nibble_out(nibble_out),
        .reg_sel(reg_sel),
        .reg16_dst(reg16_dst),
        .reg16_src(reg16_src),
        .alu_op(alu_op),
        .alu_shamt(alu_shamt),
        .alu_clk(alu_clk),
        .mva(mva),
        .mvb(mvb),
        .nibble_read(nibble_read),
        .nibble_hl(nibble_hl),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ack_at: MEM cycle on which mem_ack is high (0 never, -1 always).
    // e_done / e_err: cycle after accept on which the pulse appears (0 never).
    typedef struct {
        logic [3:0] opc;
        logic [3:0] opr;
        int         ack_at;
        int         e_done;
        int         e_err;
        int         e_mem;
        int         e_we;
        int         e_alu;
        int         e_mva;
        int         e_mvb;
        int         e_nrd;
        logic       e_nhl;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    int checks;
    int failures;
    int excl_bad;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic string nm(input int idx, input string s);
        return $sformatf("v%0d_%s", idx, s);
    endfunction

    function automatic vec_t mk(input logic [3:0] opc, input logic [3:0] opr, input int ack_at,
                                input int e_done, input int e_err, input int e_mem, input int e_we,
                                input int e_alu, input int e_mva, input int e_mvb, input int e_nrd,
                                input logic e_nhl);
        vec_t v;
        v.opc = opc; v.opr = opr; v.ack_at = ack_at;
        v.e_done = e_done; v.e_err = e_err; v.e_mem = e_mem; v.e_we = e_we;
        v.e_alu = e_alu; v.e_mva = e_mva; v.e_mvb = e_mvb; v.e_nrd = e_nrd; v.e_nhl = e_nhl;
        return v;
    endfunction

    // Per-cycle invariants: done/err never together; one activity at a time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && err) excl_bad++;
            if ((alu_clk ? 1 : 0) + (mem_req ? 1 : 0) + ((mva || mvb || nibble_read) ? 1 : 0) > 1)
                excl_bad++;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        vec_t cur;
        int   have, fin, d_cyc, e_cyc, d_cnt, e_cnt;
        int   n_mem, n_we, n_alu, n_mva, n_mvb, n_nrd, s_cyc, f_bad, h_bad, rdy_after, busy1;
        have = 0; fin = 0; d_cyc = 0; e_cyc = 0; d_cnt = 0; e_cnt = 0;
        n_mem = 0; n_we = 0; n_alu = 0; n_mva = 0; n_mvb = 0; n_nrd = 0;
        s_cyc = 0; f_bad = 0; h_bad = 0; rdy_after = -1; busy1 = 0;
        @(negedge clk);
        chk(nm(idx, "ready_in"), int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr       = {v.opc, v.opr};
        mem_ack     = (v.ack_at < 0);
        sb.push_back(v);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) begin
                instr_valid = 1'b0;
                busy1       = int'(busy);
            end
            if (done) begin d_cnt++; if (d_cyc == 0) d_cyc = i; end
            if (err)  begin e_cnt++; if (e_cyc == 0) e_cyc = i; end
            if ((done || err) && have == 0) begin
                cur  = sb.pop_front();
                have = 1;
                fin  = i;
            end
            if (fin != 0 && i == fin + 1) rdy_after = int'(instr_ready);
            n_mem += mem_req ? 1 : 0;
            n_we  += mem_we ? 1 : 0;
            n_alu += alu_clk ? 1 : 0;
            n_mva += mva ? 1 : 0;
            n_mvb += mvb ? 1 : 0;
            n_nrd += nibble_read ? 1 : 0;
            if ((mva || mvb || nibble_read) && s_cyc == 0) s_cyc = i;
            if (reg_sel != v.opr || addr_offset != v.opr || nibble_out != v.opr ||
                alu_shamt != v.opr || reg16_dst != v.opr[3:2] || reg16_src != v.opr[1:0] ||
                alu_op != v.opc[2:0])
                f_bad++;
            if (nibble_hl != v.e_nhl) h_bad++;
            mem_ack = (v.ack_at < 0) || (i == v.ack_at);
        end
        mem_ack = 1'b0;
        if (have == 0) cur = sb.pop_front();
        chk(nm(idx, "busy_c1"), busy1, 1);
        chk(nm(idx, "done_cyc"), d_cyc, cur.e_done);
        chk(nm(idx, "err_cyc"), e_cyc, cur.e_err);
        chk(nm(idx, "done_cnt"), d_cnt, (cur.e_done != 0) ? 1 : 0);
        chk(nm(idx, "err_cnt"), e_cnt, (cur.e_err != 0) ? 1 : 0);
        chk(nm(idx, "mem_req_cyc"), n_mem, cur.e_mem);
        chk(nm(idx, "mem_we_cyc"), n_we, cur.e_we);
        chk(nm(idx, "alu_clk_cyc"), n_alu, cur.e_alu);
        chk(nm(idx, "mva_cnt"), n_mva, cur.e_mva);
        chk(nm(idx, "mvb_cnt"), n_mvb, cur.e_mvb);
        chk(nm(idx, "nread_cnt"), n_nrd, cur.e_nrd);
        chk(nm(idx, "strobe_cyc"), s_cyc, (cur.e_mva + cur.e_mvb + cur.e_nrd > 0) ? 1 : 0);
        chk(nm(idx, "field_bad"), f_bad, 0);
        chk(nm(idx, "nibble_hl_bad"), h_bad, 0);
        chk(nm(idx, "ready_after"), rdy_after, 1);
    endtask

    // First instruction is followed, while busy, by a held MVB offer.
    task automatic held_pair(input string name, input logic [3:0] opc0, input logic [3:0] opr0,
                             input int exp_cyc);
        int first_mvb, n_mvb, hold_val, new_val;
        first_mvb = 0; n_mvb = 0; hold_val = -1; new_val = -1;
        @(negedge clk);
        chk({name, "_ready_in"}, int'(instr_ready), 1);
        instr_valid = 1'b1;
        instr       = {opc0, opr0};
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mvb) begin n_mvb++; if (first_mvb == 0) first_mvb = i; end
            if (i == exp_cyc - 1) hold_val = int'(reg_sel);
            if (i == exp_cyc) new_val = int'(reg_sel);
            if (i == 1) instr = {OP_MVB, 4'h6};
            if (i == exp_cyc) instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        chk({name, "_mvb_cyc"}, first_mvb, exp_cyc);
        chk({name, "_mvb_cnt"}, n_mvb, 1);
        chk({name, "_hold_opr"}, hold_val, int'(opr0));
        chk({name, "_new_opr"}, new_val, 6);
    endtask

    // Reset asserted mid-cycle on the 2nd cycle of a multi-cycle instruction.
    task automatic reset_mid(input string name, input logic [3:0] opc0, input logic [3:0] opr0);
        int act1, pulses, active;
        pulses = 0; active = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {opc0, opr0};
        @(negedge clk);
        instr_valid = 1'b0;
        act1 = int'(mem_req || alu_clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({name, "_act_c1"}, act1, 1);
        chk({name, "_outs_in_rst"}, int'({mem_req, mem_we, alu_clk, done, err, busy}), 0);
        chk({name, "_fields_in_rst"}, int'({addr_offset, alu_op}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({name, "_ready_post"}, int'(instr_ready), 1);
        for (int i = 0; i < 6; i++) begin
            if (done || err) pulses++;
            if (mem_req || alu_clk) active++;
            @(negedge clk);
        end
        chk({name, "_no_pulse"}, pulses, 0);
        chk({name, "_no_activity"}, active, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; excl_bad = 0;
        rst_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; mem_ack = 1'b0;

        //          opc     opr   ack done err mem we alu mva mvb nrd nhl
        vecs[0]  = mk(OP_MVA, 4'h9,  0, 1, 0, 0, 0, 0, 1, 0, 0, 1'b0);
        vecs[1]  = mk(OP_MVB, 4'h6,  0, 1, 0, 0, 0, 0, 0, 1, 0, 1'b0);
        vecs[2]  = mk(OP_LNL, 4'hA,  0, 1, 0, 0, 0, 0, 0, 0, 1, 1'b0);
        vecs[3]  = mk(OP_LNH, 4'h3,  0, 1, 0, 0, 0, 0, 0, 0, 1, 1'b1);
        vecs[4]  = mk(OP_NOP, 4'h0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[5]  = mk(OP_STB, 4'h5,  3, 4, 0, 3, 3, 0, 0, 0, 0, 1'b0);
        vecs[6]  = mk(OP_LDB, 4'h7,  1, 2, 0, 1, 0, 0, 0, 0, 0, 1'b0);
        vecs[7]  = mk(OP_LDB, 4'hC,  0, 0, 5, 4, 0, 0, 0, 0, 0, 1'b0);
        vecs[8]  = mk(OP_LDB, 4'h1,  4, 5, 0, 4, 0, 0, 0, 0, 0, 1'b0);
        vecs[9]  = mk(4'h3,   4'h2,  0, 3, 0, 0, 0, 3, 0, 0, 0, 1'b0);
        vecs[10] = mk(4'h0,   4'hF,  0, 3, 0, 0, 0, 3, 0, 0, 0, 1'b0);
        vecs[11] = mk(4'h7,   4'h0, -1, 3, 0, 0, 0, 3, 0, 0, 0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("rst_ctrl_outs", int'({mem_req, mem_we, alu_clk, mva, mvb, nibble_read, done, err, busy}), 0);
        chk("rst_fields", int'({addr_offset, nibble_out, reg_sel, reg16_dst, reg16_src, alu_op, alu_shamt, nibble_hl}), 0);
        chk("rst_ready", int'(instr_ready), 1);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

        held_pair("pair_mva", OP_MVA, 4'h9, 3);
        held_pair("pair_alu", 4'h1, 4'h4, 5);

        reset_mid("rst_mem", OP_LDB, 4'h2);
        reset_mid("rst_alu", 4'h2, 4'hB);

        chk("exclusive", excl_bad, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
